// File: rtl/packer_pkg.sv
// Shared types and parameters for serial_word_packer and its word_fifo2 buffer.
// The optional parity feature is controlled by the SERIAL_WORD_PACKER_PARITY_EN macro.
package packer_pkg;

    localparam int DROP_W_DEF = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    function automatic int idx_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry FIFO with registered head. A push is taken whenever a slot frees up on the
// same edge, so push+pop while full keeps two entries. A push into a full FIFO with no pop is ignored.
module word_fifo2
    import packer_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    occ_t          r_occ;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;

    occ_t          w_occ_nxt;
    logic [DW-1:0] w_head_nxt;
    logic [DW-1:0] w_tail_nxt;
    logic          w_pop;

    assign w_pop   = i_pop & (r_occ != OCC_EMPTY);
    assign o_head  = r_head;
    assign o_full  = (r_occ == OCC_FULL);
    assign o_empty = (r_occ == OCC_EMPTY);

    // Next occupancy and entry contents; the head keeps its last value once the FIFO drains.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case (r_occ)
            OCC_EMPTY: begin
                if (i_push) begin
                    w_head_nxt = i_data;
                    w_occ_nxt  = OCC_ONE;
                end else begin
                    w_occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                case ({i_push, w_pop})
                    2'b11:   w_head_nxt = i_data;
                    2'b10: begin
                        w_tail_nxt = i_data;
                        w_occ_nxt  = OCC_FULL;
                    end
                    2'b01:   w_occ_nxt = OCC_EMPTY;
                    default: w_occ_nxt = OCC_ONE;
                endcase
            end
            OCC_FULL: begin
                case ({i_push, w_pop})
                    2'b11: begin
                        w_head_nxt = r_tail;
                        w_tail_nxt = i_data;
                    end
                    2'b01: begin
                        w_head_nxt = r_tail;
                        w_occ_nxt  = OCC_ONE;
                    end
                    default: w_occ_nxt = OCC_FULL;
                endcase
            end
            default: w_occ_nxt = OCC_EMPTY;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
        end
    end

endmodule

// File: rtl/serial_word_packer.sv
// Packs an enabled serial bit stream LSB-first into W-bit words behind a 2-entry buffer.
// Define SERIAL_WORD_PACKER_PARITY_EN to add a per-word even-parity output (word_parity).
module serial_word_packer
    import packer_pkg::*;
#(
    parameter int W      = 8,
    parameter int DROP_W = DROP_W_DEF,
    localparam int IDX_W = idx_width(W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              bit_in,
    output logic [W-1:0]      word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [IDX_W-1:0]  bit_idx,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    ,
    output logic              word_parity
`endif
);

`ifdef SERIAL_WORD_PACKER_PARITY_EN
    localparam int FW = W + 1;
`else
    localparam int FW = W;
`endif

    logic [W-1:0]      r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop;

    logic [W-1:0]      w_word;
    logic [FW-1:0]     w_push_data;
    logic [FW-1:0]     w_head;
    logic              w_done;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;

    assign w_done = ena & (r_idx == IDX_W'(W - 1));
    assign w_drop = w_done & w_full & ~word_ready;

    // The final bit bypasses the shift register so the word is pushed on its own edge.
    always_comb begin
        w_word        = r_shift;
        w_word[W-1]   = bit_in;
    end

`ifdef SERIAL_WORD_PACKER_PARITY_EN
    assign w_push_data = {^w_word, w_word};
    assign word_parity = w_head[W];
`else
    assign w_push_data = w_word;
`endif

    word_fifo2 #(.DW(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_done),
        .i_pop   (word_ready),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign word_out   = w_head[W-1:0];
    assign word_valid = ~w_empty;
    assign bit_idx    = r_idx;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;

    // Partial-word accumulation; ena=0 freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (ena) begin
            r_shift[r_idx] <= bit_in;
            r_idx          <= w_done ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_shift <= r_shift;
            r_idx   <= r_idx;
        end
    end

    // Sticky overflow and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop     <= (r_drop == {DROP_W{1'b1}}) ? r_drop : r_drop + DROP_W'(1);
        end else begin
            r_overflow <= r_overflow;
            r_drop     <= r_drop;
        end
    end

endmodule

// File: tb/tb_serial_word_packer.sv
// Self-checking bench for serial_word_packer against a queue-based behavioural model.
module tb_serial_word_packer;

    localparam int W      = 8;
    localparam int DROP_W = 8;
    localparam int IDX_W  = $clog2(W);
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ena = 1'b0;
    logic              bit_in = 1'b0;
    logic              word_ready = 1'b0;
    logic [W-1:0]      word_out;
    logic              word_valid;
    logic [IDX_W-1:0]  bit_idx;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
`ifdef SERIAL_WORD_PACKER_PARITY_EN
    logic              word_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int           m_idx;
    int unsigned  m_partial;
    int unsigned  m_q[$];
    int unsigned  m_head;
    bit           m_ovf;
    int           m_drop;

    serial_word_packer #(.W(W), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .bit_in     (bit_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_idx    (bit_idx),
        .overflow   (overflow),
        .drop_count (drop_count)
`ifdef SERIAL_WORD_PACKER_PARITY_EN
        ,
        .word_parity(word_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idx = 0; m_partial = 0; m_q.delete(); m_head = 0; m_ovf = 0; m_drop = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ena = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive inputs after negedge, model the posedge, return at next negedge.
    task automatic step(input bit e, input bit b, input bit r);
        int unsigned word;
        bit done;
        ena = e; bit_in = b; word_ready = r;
        @(posedge clk);
        done = 1'b0;
        if (e) begin
            m_partial = m_partial + (int'(b) << m_idx);
            if (m_idx == W - 1) begin
                done = 1'b1; word = m_partial; m_partial = 0; m_idx = 0;
            end else begin
                m_idx = m_idx + 1;
            end
        end
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < 2) m_q.push_back(word);
            else begin
                m_ovf = 1'b1;
                if (m_drop < DMAX) m_drop = m_drop + 1;
            end
        end
        if (m_q.size() > 0) m_head = m_q[0];
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input bit r);
        for (int i = 0; i < W; i++) step(1'b1, w[i], r);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (word_valid !== 1'b0 || word_out !== 8'h00 || bit_idx !== 3'd0 ||
            overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b out=%h idx=%0d ovf=%b drop=%0d, required all zero",
                     word_valid, word_out, bit_idx, overflow, drop_count);
        end
    endtask

    task automatic test_basic_pack();
        logic [7:0] bits;
        do_reset();
        bits = 8'b0000_1101;
        for (int i = 0; i < W; i++) begin
            step(1'b1, bits[i], 1'b1);
            if (i < W - 1) begin
                n_checks++;
                if (word_valid !== 1'b0) begin
                    n_fail++; $display("FAIL basic_early_valid: got %b required 0 at bit %0d", word_valid, i);
                end
            end
        end
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 8'h0D || bit_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_word: valid=%b out=%h idx=%0d required 1/0d/0", word_valid, word_out, bit_idx);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_pop: valid=%b required 0", word_valid);
        end
    endtask

    task automatic test_enable_gaps();
        logic [7:0] bits;
        do_reset();
        bits = 8'h0D;
        for (int i = 0; i < 4; i++) step(1'b1, bits[i], 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            n_checks++;
            if (bit_idx !== 3'd4 || word_valid !== 1'b0) begin
                n_fail++; $display("FAIL gap_hold: idx=%0d valid=%b required 4/0", bit_idx, word_valid);
            end
        end
        for (int i = 4; i < W; i++) step(1'b1, bits[i], 1'b1);
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 8'h0D) begin
            n_fail++; $display("FAIL gap_word: valid=%b out=%h required 1/0d", word_valid, word_out);
        end
    endtask

    task automatic test_backpressure_drop();
        do_reset();
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
        send_word(8'hFF, 1'b0);
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 8'hA5 || overflow !== 1'b1 || drop_count !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_drop: valid=%b out=%h ovf=%b drop=%0d required 1/a5/1/1",
                     word_valid, word_out, overflow, drop_count);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 8'h3C) begin
            n_fail++; $display("FAIL bp_pop1: valid=%b out=%h required 1/3c", word_valid, word_out);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (word_valid !== 1'b0 || word_out !== 8'h3C || overflow !== 1'b1) begin
            n_fail++; $display("FAIL bp_empty: valid=%b out=%h ovf=%b required 0/3c/1", word_valid, word_out, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] w;
        do_reset();
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
        w = 8'h81;
        for (int i = 0; i < W; i++) step(1'b1, w[i], (i == W - 1));
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 8'h3C || overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL fpp_edge: valid=%b out=%h ovf=%b drop=%0d required 1/3c/0/0",
                     word_valid, word_out, overflow, drop_count);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 8'h81) begin
            n_fail++; $display("FAIL fpp_third: valid=%b out=%h required 1/81", word_valid, word_out);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (word_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fpp_drain: valid=%b ovf=%b required 0/0", word_valid, overflow);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        do_reset();
        send_word(8'h5A, 1'b0);
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        // leave one word buffered: pop once
        step(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (word_valid !== 1'b0 || bit_idx !== 3'd0 || overflow !== 1'b0 || drop_count !== 8'd0 ||
            word_out !== 8'h00) begin
            n_fail++;
            $display("FAIL async_rst: valid=%b idx=%0d ovf=%b drop=%0d out=%h required zeros",
                     word_valid, bit_idx, overflow, drop_count, word_out);
        end
        @(negedge clk);
        rst = 1'b0;
        w = 8'($urandom);
        send_word(w, 1'b0);
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== w || bit_idx !== 3'd0) begin
            n_fail++; $display("FAIL async_fresh: valid=%b out=%h required 1/%h", word_valid, word_out, w);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < DMAX + 12; k++) send_word(8'($urandom), 1'b0);
        n_checks++;
        if (drop_count !== 8'(m_drop) || m_drop != DMAX || overflow !== 1'b1) begin
            n_fail++; $display("FAIL saturate: drop=%0d ovf=%b required %0d/1", drop_count, overflow, DMAX);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            n_checks++;
            if (word_valid !== (m_q.size() > 0) || word_out !== 8'(m_head) || bit_idx !== 3'(m_idx) ||
                overflow !== m_ovf || drop_count !== 8'(m_drop)) begin
                n_fail++;
                $display("FAIL random c=%0d: valid=%b out=%h idx=%0d ovf=%b drop=%0d required %b/%h/%0d/%b/%0d",
                         c, word_valid, word_out, bit_idx, overflow, drop_count,
                         (m_q.size() > 0), 8'(m_head), m_idx, m_ovf, m_drop);
            end
`ifdef SERIAL_WORD_PACKER_PARITY_EN
            n_checks++;
            if (word_parity !== ^(8'(m_head))) begin
                n_fail++; $display("FAIL random_parity c=%0d: got %b", c, word_parity);
            end
`endif
        end
    endtask

`ifdef SERIAL_WORD_PACKER_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_word(8'h0D, 1'b0);
        n_checks++;
        if (word_parity !== 1'b1) begin
            n_fail++; $display("FAIL parity_0d: got %b required 1", word_parity);
        end
        step(1'b0, 1'b0, 1'b1);
        send_word(8'h3C, 1'b0);
        n_checks++;
        if (word_parity !== 1'b0 || word_out !== 8'h3C) begin
            n_fail++; $display("FAIL parity_3c: got %b out=%h required 0/3c", word_parity, word_out);
        end
    endtask
`endif

    initial begin
        model_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (word_valid !== 1'b0 || bit_idx !== 3'd0 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL power_on_rst: valid=%b idx=%0d drop=%0d", word_valid, bit_idx, drop_count);
        end
        test_reset();
        test_basic_pack();
        test_enable_gaps();
        test_backpressure_drop();
        test_full_push_pop();
        test_async_reset();
        test_saturation();
        test_random();
`ifdef SERIAL_WORD_PACKER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
